cla_slice_sequencer: RTL and testbench
======================================

// Module: cla_slice_sequencer
// PURPOSE
//  Multi-cycle wide adder/subtractor built on a 4-bit carry-lookahead slice. Accepts WIDTH-bit
//  operands over a valid/ready handshake, processes one 4-bit slice per clock (LSB first) and
//  chains the carry between slices. Returns sum, carry-out and signed overflow over a
//  valid/ready result handshake. Trades latency for area versus a full-width lookahead adder.
// PARAMETERS
//  WIDTH   16   operand/result width; multiple of 4, >= 4. NSLICE = WIDTH/4 (derived, localparam)
// PORTS
//  clk        in   1      single clock, rising edge
//  rst        in   1      asynchronous, active-high reset
//  in_valid   in   1      operand set valid
//  in_ready   out  1      block can accept operands (state IDLE)
//  a          in   WIDTH  operand A
//  b          in   WIDTH  operand B
//  cin        in   1      carry-in (add mode only)
//  sub        in   1      1: compute a - b; 0: compute a + b + cin
//  out_valid  out  1      result valid (state DONE)
//  out_ready  in   1      consumer accepts result
//  sum        out  WIDTH  result
//  cout       out  1      carry out of MSB (sub mode: 1 = no borrow)
//  ovf        out  1      signed overflow = carry into MSB XOR carry out of MSB
// BEHAVIOUR
//  - Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, sum=0, cout=0,
//    ovf=0, slice index=0, internal carry=0, latched operands=0.
//  - States: IDLE -> RUN on in_valid&&in_ready; RUN -> DONE after slice NSLICE-1 processed;
//    DONE -> IDLE on out_ready&&out_valid. No other transitions.
//  - Accept edge: latch a; latch b as b (add) or ~b (sub); carry = sub ? 1 : cin; idx=0.
//    cin ignored when sub=1.
//  - RUN, each edge: slice k=idx: p=a_k^b_k, g=a_k&b_k; c0=carry,
//    c[i+1]=g[i]|(p[i]&c[i]) expanded as lookahead; sum[4k+3:4k]=p^c[3:0] (per-bit carry, not
//    carry-in). carry<=c4; on k=NSLICE-1 also cout<=c4, ovf<=c3^c4 (carry into bit WIDTH-1).
//  - Latency: out_valid rises exactly NSLICE edges after the accept edge (WIDTH=16: 4 cycles).
//    Throughput: one operation per NSLICE+2 cycles minimum (DONE->IDLE takes one edge even
//    with out_ready held high; no accept on the same edge as result handoff).
//  - sum/cout/ovf: stable from out_valid rise until handoff; retain last value in IDLE/RUN
//    until overwritten slice by slice (consumers must qualify with out_valid).
//  - in_ready=0 in RUN and DONE; in_valid there is ignored, a/b/cin/sub changes ignored after
//    accept.
//  - out_ready with out_valid=0 has no effect. Backpressure: DONE held indefinitely.
//  - Reset mid-operation: operation abandoned, all outputs to reset values immediately.
//  - Width arithmetic: result modulo 2^WIDTH; cout/ovf carry the excess information.
// TESTING (WIDTH=16)
//  - Add 0xFFFF + 0x0001, cin=0 -> sum=0x0000, cout=1, ovf=0; out_valid 4 edges after accept.
//  - Add 0x7FFF + 0x0001, cin=0 -> sum=0x8000, cout=0, ovf=1; add 0x1234+0x4321,cin=1 ->
//    0x5556, cout=0, ovf=0.
//  - Sub 0x0005 - 0x0007 (cin=1 ignored) -> sum=0xFFFE, cout=0, ovf=0; 0x8000-0x0001 ->
//    0x7FFF, cout=1, ovf=1.
//  - Backpressure: out_ready=0 for 10 cycles in DONE -> out_valid, sum held; in_ready=0,
//    pulses on in_valid ignored; out_ready=1 -> IDLE next edge, in_ready=1.
//  - Reset asserted mid-RUN (after slice 1) -> out_valid=0, sum=0, in_ready=1 without clock edge;
//    next op 0x0F0F+0x00F1 -> 0x1000, cout=0.
//  - Random back-to-back ops (>=1000) with random in_valid/out_ready vs. reference model
//    a+b+cin / a-b: sum, cout, ovf match; no result dropped or duplicated.

Source files
------------

// File: rtl/cla_slice_sequencer.sv
// Purpose : multi-cycle WIDTH-bit add/subtract, one 4-bit carry-lookahead slice per clock, LSB first.
// Latency : o_out_valid rises NSLICE edges after the accept edge; one op per NSLICE+2 cycles at best.
// Backpressure: o_in_ready only in IDLE; DONE (result held stable) persists until i_out_ready.
//
// Ports:
//   i_clk, i_rst               clock (rising edge), asynchronous active-high reset
//   i_in_valid / o_in_ready    operand handshake; i_a, i_b, i_cin, i_sub sampled on accept
//   i_sub                      1: a - b (i_cin ignored), 0: a + b + i_cin
//   o_out_valid / i_out_ready  result handshake; o_sum, o_cout, o_ovf qualified by o_out_valid
//   o_cout                     carry out of MSB (subtract: 1 = no borrow)
//   o_ovf                      signed overflow (carry into MSB xor carry out of MSB)
module cla_slice_sequencer #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic             i_cin,
  input  logic             i_sub,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [WIDTH-1:0] o_sum,
  output logic             o_cout,
  output logic             o_ovf
);

  localparam int NSLICE = WIDTH / 4;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [IW-1:0]    r_idx;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_sum;
  logic             r_carry;
  logic             r_cout;
  logic             r_ovf;

  logic             w_accept;
  logic             w_last;
  logic [IW+1:0]    w_base;
  logic [3:0]       w_sa;
  logic [3:0]       w_sb;
  logic [3:0]       w_p;
  logic [3:0]       w_g;
  logic [4:0]       w_c;
  logic [3:0]       w_s;

  // Slice selection and 4-bit lookahead carry network.
  always_comb begin
    w_base = {r_idx, 2'b00};
    w_sa   = r_a[w_base +: 4];
    w_sb   = r_b[w_base +: 4];
    w_p    = w_sa ^ w_sb;
    w_g    = w_sa & w_sb;
    w_c[0] = r_carry;
    w_c[1] = w_g[0] | (w_p[0] & w_c[0]);
    w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & w_c[0]);
    w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
           | (w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    w_c[4] = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
           | (w_p[3] & w_p[2] & w_p[1] & w_g[0])
           | (w_p[3] & w_p[2] & w_p[1] & w_p[0] & w_c[0]);
    // Each sum bit uses the carry into that bit, not the slice carry-in.
    w_s    = w_p ^ w_c[3:0];
  end

  assign w_last = (r_idx == IW'(NSLICE - 1));

  // State register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and handshake outputs.
  always_comb begin
    w_state_nxt = r_state;
    o_in_ready  = 1'b0;
    o_out_valid = 1'b0;
    w_accept    = 1'b0;
    case (r_state)
      S_IDLE: begin
        o_in_ready = 1'b1;
        if (i_in_valid) begin
          w_accept    = 1'b1;
          w_state_nxt = S_RUN;
        end
      end
      S_RUN: begin
        if (w_last) begin
          w_state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        o_out_valid = 1'b1;
        if (i_out_ready) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Datapath: operand latch on accept, then one slice per RUN edge.
  // Subtraction is a + ~b + 1, so the inverted b and a forced carry-in are latched up front.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_idx   <= '0;
      r_carry <= 1'b0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_a     <= i_a;
      r_b     <= i_sub ? ~i_b : i_b;
      r_carry <= i_sub | i_cin;
      r_idx   <= '0;
    end else if (r_state == S_RUN) begin
      r_sum[w_base +: 4] <= w_s;
      r_carry            <= w_c[4];
      r_idx              <= r_idx + 1'b1;
      if (w_last) begin
        r_cout <= w_c[4];
        r_ovf  <= w_c[3] ^ w_c[4];
      end
    end
  end

  assign o_sum  = r_sum;
  assign o_cout = r_cout;
  assign o_ovf  = r_ovf;

endmodule

// File: tb/tb_cla_slice_sequencer.sv
module tb_cla_slice_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  cla_slice_sequencer #(.WIDTH(16)) dut (
    .i_clk      (clk),
    .i_rst      (rst),
    .i_in_valid (in_valid),
    .o_in_ready (in_ready),
    .i_a        (a),
    .i_b        (b),
    .i_cin      (cin),
    .i_sub      (sub),
    .o_out_valid(out_valid),
    .i_out_ready(out_ready),
    .o_sum      (sum),
    .o_cout     (cout),
    .o_ovf      (ovf)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: plain integer arithmetic, result packed as {ovf, cout, sum}.
  function automatic logic [17:0] model(input logic [15:0] ma, input logic [15:0] mb,
                                        input logic mci, input logic ms);
    int ua, ub, sa, sb, r, sr;
    logic mc, mo;
    logic [31:0] rv;
    ua = int'(ma);
    ub = int'(mb);
    sa = int'($signed(ma));
    sb = int'($signed(mb));
    if (ms) begin
      r  = ua - ub;
      mc = (ua >= ub);
      sr = sa - sb;
    end else begin
      r  = ua + ub + int'(mci);
      mc = (r > 65535);
      sr = sa + sb + int'(mci);
    end
    mo = (sr > 32767) || (sr < -32768);
    rv = r;
    return {mo, mc, rv[15:0]};
  endfunction

  task automatic run_op(input string tag, input logic [15:0] ia, input logic [15:0] ib,
                        input logic ci, input logic s, input logic [15:0] es,
                        input logic ec, input logic eo, input int hold);
    int lat;
    chk({tag, ":in_ready"}, in_ready, 1);
    a = ia; b = ib; cin = ci; sub = s; in_valid = 1'b1; out_ready = 1'b0;
    step();
    // Operand changes after accept must not matter.
    in_valid = 1'b0; a = 16'($urandom); b = 16'($urandom); cin = ~ci; sub = ~s;
    chk({tag, ":busy"}, in_ready, 0);
    lat = 0;
    while (!out_valid && lat < 20) begin
      step();
      lat++;
    end
    chk({tag, ":latency"}, lat, 4);
    chk({tag, ":sum"}, sum, es);
    chk({tag, ":cout"}, cout, ec);
    chk({tag, ":ovf"}, ovf, eo);
    for (int i = 0; i < hold; i++) begin
      in_valid = ~in_valid;
      a = 16'($urandom);
      step();
      chk({tag, ":hold_vld"}, out_valid, 1);
      chk({tag, ":hold_sum"}, sum, es);
      chk({tag, ":hold_rdy"}, in_ready, 0);
    end
    in_valid = 1'b0; out_ready = 1'b1;
    step();
    chk({tag, ":handoff_vld"}, out_valid, 0);
    chk({tag, ":handoff_rdy"}, in_ready, 1);
    out_ready = 1'b0; cin = 1'b0; sub = 1'b0;
    if (hold > 0) begin
      step();
      chk({tag, ":no_phantom"}, in_ready, 1);
    end
  endtask

  initial begin
    logic [17:0] q[$];
    logic [17:0] got;
    int age;
    int done_n;
    bit acc, hand;

    #2;
    chk("reset:in_ready", in_ready, 1);
    chk("reset:out_valid", out_valid, 0);
    chk("reset:sum", sum, 0);
    chk("reset:cout", cout, 0);
    chk("reset:ovf", ovf, 0);
    #10 rst = 1'b0;
    step();

    run_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 0);
    run_op("add_ovf",  16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 0);
    run_op("add_cin",  16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 0);
    run_op("sub_neg",  16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0, 0);
    run_op("sub_ovf",  16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1, 0);
    run_op("backpress", 16'h1234, 16'h4321, 1'b1, 1'b0, 16'h5556, 1'b0, 1'b0, 10);

    // Reset in the middle of RUN, after slices 0 and 1.
    a = 16'h1234; b = 16'h1111; in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    #2 rst = 1'b1;
    #1;
    chk("midrst:out_valid", out_valid, 0);
    chk("midrst:sum", sum, 0);
    chk("midrst:in_ready", in_ready, 1);
    chk("midrst:cout", cout, 0);
    #4 rst = 1'b0;
    step();
    run_op("after_rst", 16'h0F0F, 16'h00F1, 1'b0, 1'b0, 16'h1000, 1'b0, 1'b0, 0);

    // Random traffic against the integer model, with an outstanding-op tracker.
    age = 0;
    done_n = 0;
    for (int cyc = 0; cyc < 40000 && done_n < 1000; cyc++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      a         = 16'($urandom);
      b         = 16'($urandom);
      cin       = 1'($urandom);
      sub       = 1'($urandom);
      out_ready = ($urandom_range(0, 2) != 0);
      #1;
      chk("rnd:in_ready", in_ready, (q.size() == 0));
      chk("rnd:out_valid", out_valid, (q.size() != 0 && age >= 4));
      acc  = in_valid && (q.size() == 0);
      hand = out_ready && (q.size() != 0) && (age >= 4);
      if (hand) begin
        got = {ovf, cout, sum};
        chk("rnd:result", got, q[0]);
        void'(q.pop_front());
        done_n++;
      end
      if (acc) begin
        q.push_back(model(a, b, cin, sub));
      end
      step();
      if (acc) age = 0;
      else if (q.size() != 0) age++;
    end
    chk("rnd:completed", (done_n >= 1000), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
